bus_rr_arbiter: RTL and testbench
=================================

// Module: bus_rr_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer for the shared 4-bit unidirectional tri-state bus.
//  Up to N_REQ sources each drive the bus through their own tri-state driver (enable c).
//  This block grants one source at a time and produces the one-hot drv_en vector that feeds those c inputs.
//  It inserts a turnaround cycle between owners and caps the hold time, so the bus never sees contention or starvation.
// PARAMETERS
//  N_REQ     4  number of requesters (>=2)
//  MAX_HOLD  8  max consecutive drv_en cycles per grant (>=1)
//  IDX_W     $clog2(N_REQ)  owner index width (derived, not overridden)
// PORTS
//  clk     in   1      system clock, rising edge
//  rst     in   1      asynchronous, active-high reset
//  req     in   N_REQ  request per source, level, held until done with bus
//  gnt     out  N_REQ  one-hot grant (registered)
//  drv_en  out  N_REQ  one-hot tri-state enable to each source's bus driver (registered)
//  owner   out  IDX_W  index of granted source, valid when busy=1
//  busy    out  1      a grant is active (TURN or HOLD)
// BEHAVIOUR
//  Clocking and reset
//  - One clock, clk. Reset rst is asynchronous and active-high.
//  - On rst: gnt=0, drv_en=0, owner=0, busy=0, state=IDLE, rr pointer ptr=0, hold_cnt=0.
//  - Outputs clear immediately on rst assertion, without waiting for a clock edge.
//  Round-robin pick
//  - Combinational search of req starting at index ptr, wrapping N_REQ-1 -> 0.
//  - The first set bit wins.
//  FSM states: IDLE, TURN, HOLD.
//  - IDLE: if |req, register the pick: gnt=onehot, owner=idx, busy=1 -> TURN. Else stay.
//  - TURN (1 cycle): gnt asserted, drv_en=0. This is the dead cycle that lets the previous driver release.
//    - If req[owner]=1 -> HOLD next cycle, with drv_en=gnt and hold_cnt=1.
//    - If req[owner] dropped -> release (see below). drv_en never asserts.
//  - HOLD: drv_en=gnt, hold_cnt increments each cycle.
//    - Release when req[owner]=0 (sampled) OR hold_cnt==MAX_HOLD.
//  Release
//  - drv_en clears on the next edge.
//  - ptr = owner+1 (mod N_REQ). The pick uses this new ptr in the same cycle.
//  - If any req is pending -> TURN with the new gnt/owner. Else gnt=0, busy=0 -> IDLE.
//  Latency
//  - req rising in IDLE at edge k -> gnt at k+1 -> drv_en at k+2.
//  - Owner change: exactly one cycle with drv_en=0 between drv_en of the old owner and the new owner.
//  Timeout and drop timing
//  - On timeout, the owner may be re-granted if it is the only requester.
//    It still passes through TURN, so there is one drv_en=0 cycle.
//  - A req drop takes effect one cycle late: the owner may see drv_en for one cycle after lowering req.
//    Sources must tolerate this or tri-state their own data.
//  Widths and invariants
//  - hold_cnt is $clog2(MAX_HOLD+1) bits and never exceeds MAX_HOLD.
//  - Invariants: $onehot0(drv_en); $onehot0(gnt); drv_en & ~gnt == 0; busy == |gnt; drv_en==0 in IDLE and TURN.
//  - req bits of non-owners are ignored while a grant is held.
//  - Reset mid-HOLD abandons the transfer. After rst is released, arbitration restarts from ptr=0.
// STRUCTURE
//  - Package bus_arb_pkg: typedef enum logic[1:0] {IDLE, TURN, HOLD} arb_state_t; default N_REQ and MAX_HOLD constants.
//  - Sub-module rr_pick: combinational; inputs req, ptr; outputs onehot, idx, any.
//  - Top: FSM, hold counter, ptr register, output registers.
//  - The 4-bit tri-state drivers live outside this block; each drv_en[i] connects to driver i's c.
// TESTING  (N_REQ=4, MAX_HOLD=4)
//  1. After reset, req=0001 at edge 0 -> gnt=0001 and busy=1 at edge 1; drv_en=0001 at edge 2; owner=0.
//  2. req=1111 held -> owners 0,1,2,3,0 in turn.
//     Each owner gets 4 drv_en cycles, then 1 all-zero cycle. drv_en is never multi-hot.
//  3. Owner 2 alone drops req after 2 HOLD cycles -> drv_en=0, gnt=0, busy=0 next edge; state IDLE; ptr=3.
//  4. req=0011 and owner 0 drops req during TURN -> drv_en[0] never asserts; next edge gnt=0010 (TURN).
//  5. rst pulsed mid-HOLD with drv_en=0100, between clock edges -> gnt and drv_en read 0 before the next edge.
//     Then req=1010 -> source 1 granted first (ptr=0).
//  6. req=0010 held 12 cycles -> drv_en[1] follows 4 on, 1 off, repeating; gnt stays 0010; owner stays 1.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and default sizing for the round-robin bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {IDLE, TURN, HOLD} arb_state_t;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/bus_rr_arbiter_pick.sv
// Combinational round-robin search: first set req bit at or after ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] k;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    k      = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && req[k]) begin
        any       = 1'b1;
        idx       = k;
        onehot[k] = 1'b1;
      end
      k = (k == IDX_W'(N_REQ - 1)) ? '0 : k + IDX_W'(1);
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin owner sequencing for a shared tri-state bus, with a dead turnaround
// cycle between owners and a cap on consecutive drive cycles.
//   state | meaning
//   IDLE  | no grant, waiting for any req
//   TURN  | gnt held, drv_en low for one cycle so the previous driver can release
//   HOLD  | owner drives the bus, hold_cnt counts drive cycles up to MAX_HOLD
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  localparam int IDX_W   = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] drv_en,
  output logic [IDX_W-1:0] owner,
  output logic             busy
);

  localparam int HC_W = $clog2(MAX_HOLD + 1);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner_inc;
  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_oh;
  logic             pick_any;
  logic [HC_W-1:0]  hold_cnt;
  logic             own_req;
  logic             hold_done;
  logic             release_now;

  assign owner_inc = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);
  // On release the search must already start past the outgoing owner.
  assign pick_ptr  = (state == IDLE) ? ptr : owner_inc;
  assign own_req   = req[owner];
  assign hold_done = (hold_cnt == HC_W'(MAX_HOLD));
  assign release_now = ((state == TURN) && !own_req) ||
                       ((state == HOLD) && (!own_req || hold_done));

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      drv_en   <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else if (release_now) begin
      drv_en   <= '0;
      hold_cnt <= '0;
      ptr      <= owner_inc;
      if (pick_any) begin
        gnt   <= pick_oh;
        owner <= pick_idx;
        state <= TURN;
      end else begin
        gnt   <= '0;
        busy  <= 1'b0;
        state <= IDLE;
      end
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt   <= pick_oh;
            owner <= pick_idx;
            busy  <= 1'b1;
            state <= TURN;
          end
        end
        TURN: begin
          drv_en   <= gnt;
          hold_cnt <= HC_W'(1);
          state    <= HOLD;
        end
        HOLD: hold_cnt <= hold_cnt + HC_W'(1);
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed vector table, corner sequences, and a
// randomized run against an owner/age reference model.
module tb_bus_rr_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [3:0] drv_en;
  logic [1:0] owner;
  logic       busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_rr_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .gnt    (gnt),
    .drv_en (drv_en),
    .owner  (owner),
    .busy   (busy)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] drv;
    logic [1:0] own;
    logic       busy;
  } vec_t;

  vec_t vecs[12];

  // reference model: owner (-1 = none), age = drive cycles so far (0 = turnaround)
  int m_owner;
  int m_age;
  int m_ptr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int start);
    for (int i = 0; i < N; i++) begin
      if (r[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r);
    if (m_owner < 0) begin
      m_owner = pick(r, m_ptr);
      m_age   = 0;
    end else if (r[m_owner] && m_age < MH) begin
      m_age++;
    end else begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = pick(r, m_ptr);
      m_age   = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_drv", drv_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    rst = 1'b0;
    m_owner = -1;
    m_age   = 0;
    m_ptr   = 0;
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] eg;
    logic [3:0] ed;

    vecs[0]  = '{4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b1};
    vecs[1]  = '{4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1};
    vecs[2]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[3]  = '{4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b1};
    vecs[4]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[5]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[6]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[7]  = '{4'b1100, 4'b1000, 4'b0000, 2'd3, 1'b1};
    vecs[8]  = '{4'b0011, 4'b0001, 4'b0000, 2'd0, 1'b1};
    vecs[9]  = '{4'b0010, 4'b0010, 4'b0000, 2'd1, 1'b1};
    vecs[10] = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1};
    vecs[11] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      req = vecs[i].req;
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i), gnt, vecs[i].gnt);
      chk($sformatf("vec%0d_drv", i), drv_en, vecs[i].drv);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      if (vecs[i].busy) chk($sformatf("vec%0d_owner", i), owner, vecs[i].own);
    end

    // all sources requesting: owners rotate, 4 drive cycles each, 1 dead cycle between
    do_reset();
    req = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      @(negedge clk);
      chk("rr_turn_gnt", gnt, 4'b0001 << (o % N));
      chk("rr_turn_drv", drv_en, 0);
      chk("rr_turn_owner", owner, o % N);
      for (int h = 0; h < MH; h++) begin
        @(negedge clk);
        chk("rr_hold_drv", drv_en, 4'b0001 << (o % N));
        chk("rr_hold_gnt", gnt, 4'b0001 << (o % N));
      end
    end

    // lone requester held: timeout re-grants itself through a dead cycle
    do_reset();
    req = 4'b0010;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("solo_drv", drv_en, (c % 5 != 0) ? 4'b0010 : 4'b0000);
      chk("solo_gnt", gnt, 4'b0010);
      chk("solo_owner", owner, 1);
    end

    // asynchronous reset in the middle of a drive phase
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_drv", drv_en, 4'b0100);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_gnt", gnt, 0);
    chk("async_rst_drv", drv_en, 0);
    chk("async_rst_busy", busy, 0);
    #1 rst = 1'b0;
    req = 4'b1010;
    @(negedge clk);
    chk("post_rst_gnt", gnt, 4'b0010);
    chk("post_rst_owner", owner, 1);
    chk("post_rst_busy", busy, 1);

    // randomized run against the reference model
    do_reset();
    r = 4'b0000;
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(3) == 0) r[b] = ~r[b];
      end
      req = r;
      model_step(r);
      @(negedge clk);
      eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      ed = (m_owner >= 0 && m_age > 0) ? eg : 4'b0000;
      chk("rnd_gnt", gnt, eg);
      chk("rnd_drv", drv_en, ed);
      chk("rnd_busy", busy, (m_owner >= 0) ? 1 : 0);
      if (m_owner >= 0) chk("rnd_owner", owner, m_owner);
      chk("rnd_drv_onehot0", $onehot0(drv_en), 1);
      chk("rnd_drv_in_gnt", drv_en & ~gnt, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
